// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared constants and resolution helper for the set/reset flop bank
package sr_pkg;

   // Resolution of a qualified s=r=1 request
   localparam int SR_SET_DOM = 0;
   localparam int SR_RST_DOM = 1;
   localparam int SR_HOLD    = 2;
   localparam int SR_TOGGLE  = 3;

   // Request codes, packed as {r, s}
   localparam logic [1:0] SR_NONE = 2'b00;
   localparam logic [1:0] SR_SET  = 2'b01;
   localparam logic [1:0] SR_RST  = 2'b10;
   localparam logic [1:0] SR_BOTH = 2'b11;

   // Next stored value for a qualified request code
   function automatic logic sr_next(input logic [1:0] code, input logic cur, input int mode);
      logic nxt;
      nxt = cur;
      case (code)
         SR_SET:  nxt = 1'b1;
         SR_RST:  nxt = 1'b0;
         SR_BOTH: begin
            case (mode)
               SR_SET_DOM: nxt = 1'b1;
               SR_RST_DOM: nxt = 1'b0;
               SR_TOGGLE:  nxt = ~cur;
               default:    nxt = cur;
            endcase
         end
         default: nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_chan.sv
// rtl/sr_chan.sv - one filtered set/reset storage channel with change pulse and sticky conflict
module sr_chan
   import sr_pkg::*;
#(
   parameter int   MODE    = 0,
   parameter int   FILT    = 0,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s,
   input  logic r,
   input  logic en,
   input  logic conflict_clr,
   output logic q,
   output logic q_b,
   output logic chg,
   output logic conflict
);

   localparam logic [7:0] FILT_C = 8'(FILT);

   logic [1:0] code;
   logic [1:0] last;
   logic [7:0] cnt;
   logic       qual;
   logic       q_nxt;
   logic       both_hit;

   // Qualify the current code and compute the resolved next value
   always_comb begin
      code     = {r, s};
      qual     = (code == last) && (cnt == FILT_C);
      q_nxt    = qual ? sr_next(code, q, MODE) : q;
      both_hit = en && qual && (code == SR_BOTH) && (MODE != SR_TOGGLE);
   end

   // Stability filter: restart on a new code, saturate the count at FILT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last <= SR_NONE;
         cnt  <= 8'd0;
      end else if (en) begin
         if (code != last) begin
            last <= code;
            cnt  <= 8'd0;
         end else if (cnt != FILT_C) begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   // Storage with its complement and the change pulse, all from the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= RST_VAL;
         q_b <= ~RST_VAL;
         chg <= 1'b0;
      end else if (en) begin
         q   <= q_nxt;
         q_b <= ~q_nxt;
         chg <= q_nxt ^ q;
      end else begin
         chg <= 1'b0;
      end
   end

   // Sticky conflict flag; a new conflict beats a clear on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conflict <= 1'b0;
      end else if (both_hit) begin
         conflict <= 1'b1;
      end else if (conflict_clr) begin
         conflict <= 1'b0;
      end
   end

endmodule

// File: rtl/sr_flop_bank.sv
// rtl/sr_flop_bank.sv - bank of WIDTH independent filtered set/reset channels
module sr_flop_bank
   import sr_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter int               MODE    = 0,
   parameter int               FILT    = 0,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   input  logic             en,
   input  logic [WIDTH-1:0] conflict_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_b,
   output logic [WIDTH-1:0] chg,
   output logic [WIDTH-1:0] conflict
);

   // Reject parameter values the channels cannot represent
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("sr_flop_bank: WIDTH must be 1..32");
   end
   if (MODE < 0 || MODE > 3) begin : g_bad_mode
      $error("sr_flop_bank: MODE must be 0..3");
   end
   if (FILT < 0 || FILT > 255) begin : g_bad_filt
      $error("sr_flop_bank: FILT must be 0..255");
   end

   // One channel per bit; channels share only clock, reset and enable
   for (genvar i = 0; i < WIDTH; i++) begin : g_chan
      sr_chan #(
         .MODE    (MODE),
         .FILT    (FILT),
         .RST_VAL (RST_VAL[i])
      ) u_chan (
         .clk          (clk),
         .rst_n        (rst_n),
         .s            (s[i]),
         .r            (r[i]),
         .en           (en),
         .conflict_clr (conflict_clr[i]),
         .q            (q[i]),
         .q_b          (q_b[i]),
         .chg          (chg[i]),
         .conflict     (conflict[i])
      );
   end

endmodule

// File: tb/tb_sr_flop_bank.sv
// tb/tb_sr_flop_bank.sv - directed self-checking bench for sr_flop_bank
module tb_sr_flop_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s = '0, r = '0, clr = '0;
   logic       en = 1'b1;

   logic [7:0] q0, qb0, chg0, cf0;
   logic [7:0] q1, qb1, chg1, cf1;
   logic [7:0] q2, qb2, chg2, cf2;
   logic [7:0] q3, qb3, chg3, cf3;
   logic [7:0] qf, qbf, chgf, cff;
   logic       qw, qbw, chgw, cfw;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   sr_flop_bank #(.WIDTH(8), .MODE(0), .FILT(0), .RST_VAL(8'hA5)) u0 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .conflict_clr(clr),
      .q(q0), .q_b(qb0), .chg(chg0), .conflict(cf0));
   sr_flop_bank #(.WIDTH(8), .MODE(1), .FILT(0), .RST_VAL(8'h00)) u1 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .conflict_clr(clr),
      .q(q1), .q_b(qb1), .chg(chg1), .conflict(cf1));
   sr_flop_bank #(.WIDTH(8), .MODE(2), .FILT(0), .RST_VAL(8'h00)) u2 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .conflict_clr(clr),
      .q(q2), .q_b(qb2), .chg(chg2), .conflict(cf2));
   sr_flop_bank #(.WIDTH(8), .MODE(3), .FILT(0), .RST_VAL(8'h00)) u3 (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .conflict_clr(clr),
      .q(q3), .q_b(qb3), .chg(chg3), .conflict(cf3));
   sr_flop_bank #(.WIDTH(8), .MODE(0), .FILT(3), .RST_VAL(8'h00)) uf (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .conflict_clr(clr),
      .q(qf), .q_b(qbf), .chg(chgf), .conflict(cff));
   sr_flop_bank #(.WIDTH(1), .MODE(3), .FILT(255), .RST_VAL(1'b0)) uw (
      .clk(clk), .rst_n(rst_n), .s(s[0]), .r(r[0]), .en(en), .conflict_clr(clr[0]),
      .q(qw), .q_b(qbw), .chg(chgw), .conflict(cfw));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; s = '0; r = '0; clr = '0; en = 1'b1;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; s = '0; r = '0; clr = '0; en = 1'b1;
      step();
      step();
      checks++; if (q0 !== 8'hA5) $display("FAIL reset_q got %h want a5", q0); else passed++;
      checks++; if (qb0 !== 8'h5A) $display("FAIL reset_qb got %h want 5a", qb0); else passed++;
      checks++; if (chg0 !== 8'h00) $display("FAIL reset_chg got %h want 00", chg0); else passed++;
      checks++; if (cf0 !== 8'h00) $display("FAIL reset_conflict got %h want 00", cf0); else passed++;
      checks++; if (q1 !== 8'h00 || qb1 !== 8'hFF) $display("FAIL reset_q_u1 got %h/%h want 00/ff", q1, qb1); else passed++;
      rst_n = 1'b1;
   endtask

   task automatic test_filt0();
      r = 8'h01;
      step();
      checks++; if (q0 !== 8'hA5) $display("FAIL f0_clr_first_edge got %h want a5", q0); else passed++;
      step();
      checks++; if (q0 !== 8'hA4 || qb0 !== 8'h5B) $display("FAIL f0_clr_q got %h/%h want a4/5b", q0, qb0); else passed++;
      checks++; if (chg0 !== 8'h01) $display("FAIL f0_clr_chg got %h want 01", chg0); else passed++;
      r = 8'h00; s = 8'h01;
      step();
      checks++; if (q0 !== 8'hA4 || chg0 !== 8'h00) $display("FAIL f0_set_first_edge got %h/%h want a4/00", q0, chg0); else passed++;
      step();
      checks++; if (q0 !== 8'hA5 || chg0 !== 8'h01) $display("FAIL f0_set_q got %h/%h want a5/01", q0, chg0); else passed++;
      s = 8'h00;
      step();
      checks++; if (chg0 !== 8'h00) $display("FAIL f0_chg_single got %h want 00", chg0); else passed++;
   endtask

   task automatic test_filt3();
      do_reset();
      s = 8'h02;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (qf !== 8'h00) $display("FAIL f3_short_edge%0d got %h want 00", i, qf); else passed++;
      end
      s = 8'h00;
      step();
      step();
      checks++; if (qf !== 8'h00) $display("FAIL f3_short_after got %h want 00", qf); else passed++;
      s = 8'h02;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if (qf !== ((i == 5) ? 8'h02 : 8'h00))
            $display("FAIL f3_held_edge%0d got %h want %h", i, qf, (i == 5) ? 8'h02 : 8'h00);
         else passed++;
      end
      checks++; if (chgf !== 8'h02) $display("FAIL f3_held_chg got %h want 02", chgf); else passed++;
      s = 8'h00; r = 8'h02;
      step();
      step();
      s = 8'h02; r = 8'h00;
      step();
      s = 8'h00; r = 8'h02;
      for (int i = 4; i <= 8; i++) begin
         step();
         checks++;
         if (qf !== ((i == 8) ? 8'h00 : 8'h02))
            $display("FAIL f3_restart_edge%0d got %h want %h", i, qf, (i == 8) ? 8'h00 : 8'h02);
         else passed++;
      end
      r = 8'h00;
   endtask

   task automatic test_reset_midcount();
      do_reset();
      s = 8'h04;
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if (qf !== ((i == 5) ? 8'h04 : 8'h00))
            $display("FAIL midreset_edge%0d got %h want %h", i, qf, (i == 5) ? 8'h04 : 8'h00);
         else passed++;
      end
      s = 8'h00;
   endtask

   task automatic test_modes();
      do_reset();
      s = 8'h08;
      step();
      step();
      checks++; if (q0 !== 8'hAD || q1 !== 8'h08 || q3 !== 8'h08) $display("FAIL modes_preset got %h/%h/%h want ad/08/08", q0, q1, q3); else passed++;
      r = 8'h08;
      step();
      checks++; if (cf0 !== 8'h00 || q1 !== 8'h08) $display("FAIL modes_unqualified got %h/%h want 00/08", cf0, q1); else passed++;
      step();
      checks++; if (q0 !== 8'hAD || cf0 !== 8'h08) $display("FAIL mode0_both got %h/%h want ad/08", q0, cf0); else passed++;
      checks++; if (q1 !== 8'h00 || cf1 !== 8'h08 || chg1 !== 8'h08) $display("FAIL mode1_both got %h/%h/%h want 00/08/08", q1, cf1, chg1); else passed++;
      checks++; if (q2 !== 8'h08 || cf2 !== 8'h08 || chg2 !== 8'h00) $display("FAIL mode2_both got %h/%h/%h want 08/08/00", q2, cf2, chg2); else passed++;
      checks++; if (q3 !== 8'h00 || cf3 !== 8'h00 || chg3 !== 8'h08) $display("FAIL mode3_both got %h/%h/%h want 00/00/08", q3, cf3, chg3); else passed++;
      step();
      checks++; if (q3 !== 8'h08 || qb3 !== 8'hF7) $display("FAIL mode3_toggle got %h/%h want 08/f7", q3, qb3); else passed++;
      checks++; if (q1 !== 8'h00 || chg1 !== 8'h00) $display("FAIL mode1_sustain got %h/%h want 00/00", q1, chg1); else passed++;
   endtask

   task automatic test_conflict();
      clr = 8'h08;
      step();
      checks++; if (cf0 !== 8'h08) $display("FAIL conflict_set_wins got %h want 08", cf0); else passed++;
      s = 8'h00; r = 8'h00; en = 1'b0;
      step();
      checks++; if (cf0 !== 8'h00 || cf1 !== 8'h00) $display("FAIL conflict_clr_en0 got %h/%h want 00/00", cf0, cf1); else passed++;
      checks++; if (q0 !== 8'hAD || chg0 !== 8'h00) $display("FAIL conflict_en0_frozen got %h/%h want ad/00", q0, chg0); else passed++;
      clr = 8'h00; en = 1'b1;
   endtask

   task automatic test_enable();
      do_reset();
      en = 1'b0; s = 8'hFF;
      for (int i = 1; i <= 5; i++) begin
         step();
         checks++;
         if (qf !== 8'h00 || chgf !== 8'h00 || q0 !== 8'hA5)
            $display("FAIL en0_cycle%0d got %h/%h/%h want 00/00/a5", i, qf, chgf, q0);
         else passed++;
      end
      en = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         step();
         if (i == 1) begin
            checks++; if (q0 !== 8'hA5) $display("FAIL en1_u0_edge1 got %h want a5", q0); else passed++;
         end
         if (i == 2) begin
            checks++; if (q0 !== 8'hFF || chg0 !== 8'h5A) $display("FAIL en1_u0_edge2 got %h/%h want ff/5a", q0, chg0); else passed++;
         end
         checks++;
         if (qf !== ((i == 5) ? 8'hFF : 8'h00))
            $display("FAIL en1_filt_edge%0d got %h want %h", i, qf, (i == 5) ? 8'hFF : 8'h00);
         else passed++;
      end
      checks++; if (chgf !== 8'hFF || qbf !== 8'h00) $display("FAIL en1_filt_chg got %h/%h want ff/00", chgf, qbf); else passed++;
      s = 8'h00;
   endtask

   task automatic test_filt255();
      do_reset();
      s = 8'h01; r = 8'h01;
      for (int i = 1; i <= 256; i++) step();
      checks++; if (qw !== 1'b0) $display("FAIL f255_edge256 got %b want 0", qw); else passed++;
      step();
      checks++; if (qw !== 1'b1 || qbw !== 1'b0) $display("FAIL f255_edge257 got %b/%b want 1/0", qw, qbw); else passed++;
      step();
      checks++; if (qw !== 1'b0 || chgw !== 1'b1) $display("FAIL f255_saturate1 got %b/%b want 0/1", qw, chgw); else passed++;
      step();
      checks++; if (qw !== 1'b1 || cfw !== 1'b0) $display("FAIL f255_saturate2 got %b/%b want 1/0", qw, cfw); else passed++;
      s = 8'h00; r = 8'h00;
   endtask

   initial begin
      test_reset();
      test_filt0();
      test_filt3();
      test_reset_midcount();
      test_modes();
      test_conflict();
      test_enable();
      test_filt255();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
